// File: rtl/alu_cdb_writer_pkg.sv
// ALU-to-CDB writer shared definitions.
// Widths, opcodes and the queued result entry.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif
`ifndef ALUCDB_FIFO_DEPTH
`define ALUCDB_FIFO_DEPTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_SLT  4'd8
`define ALU_SLTU 4'd9
`define ALU_LUI  4'd10
`endif

package alu_cdb_writer_pkg;

  localparam int OP_W  = `ALU_OP_WIDTH;
  localparam int ROB_W = `ROB_ENTRY_WIDTH;

  typedef struct packed {
    logic [ROB_W-1:0] tag;
    logic [31:0]      data;
  } cdb_entry_t;

endpackage

// File: rtl/alu_cdb_writer_if.sv
// Reservation-station input and CDB bus bundle.
// master drives operands/grant, slave is the writer.
interface alu_cdb_writer_if;

  logic [`ALU_OP_WIDTH-1:0]    Op_in;
  logic [31:0]                 Vj_in;
  logic [31:0]                 Vk_in;
  logic [`ROB_ENTRY_WIDTH-1:0] Dest_in;
  logic                        flush;
  logic                        cdb_grant;
  logic                        cdb_req;
  logic [`ROB_ENTRY_WIDTH-1:0] CDB_ALU_ROB_index;
  logic [31:0]                 CDB_ALU_data;

  modport master (
    output Op_in, Vj_in, Vk_in, Dest_in,
    output flush, cdb_grant,
    input  cdb_req, CDB_ALU_ROB_index,
    input  CDB_ALU_data
  );

  modport slave (
    input  Op_in, Vj_in, Vk_in, Dest_in,
    input  flush, cdb_grant,
    output cdb_req, CDB_ALU_ROB_index,
    output CDB_ALU_data
  );

endinterface

// File: rtl/alu_cdb_writer_alu_core.sv
// Combinational integer ALU datapath.
// Unknown opcodes produce zero.
module alu_core (
  input  logic [`ALU_OP_WIDTH-1:0] op,
  input  logic [31:0]              a,
  input  logic [31:0]              b,
  output logic [31:0]              result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // opcode decode to result
  always_comb begin
    result = '0;
    case (op)
      `ALU_ADD:  result = a + b;
      `ALU_SUB:  result = a - b;
      `ALU_AND:  result = a & b;
      `ALU_OR:   result = a | b;
      `ALU_XOR:  result = a ^ b;
      `ALU_SLL:  result = a << shamt;
      `ALU_SRL:  result = a >> shamt;
      `ALU_SRA:  result = $signed(a) >>> shamt;
      `ALU_SLT:
        result = {31'd0, $signed(a) < $signed(b)};
      `ALU_SLTU: result = {31'd0, a < b};
      `ALU_LUI:  result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_cdb_writer.sv
// ALU result queue feeding the common data bus.
// One-cycle latency, strict FIFO order, sticky overflow.
module alu_cdb_writer
  import alu_cdb_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = `ALUCDB_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  alu_cdb_writer_if.slave             bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        almost_full,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  cdb_entry_t    mem [FIFO_DEPTH];
  logic [31:0]   result;

  logic valid_in;
  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  alu_core u_alu (
    .op     (bus.Op_in),
    .a      (bus.Vj_in),
    .b      (bus.Vk_in),
    .result (result)
  );

  // push/pop decisions; flush squashes both
  always_comb begin
    valid_in = (bus.Dest_in != '0);
    full     = (count == CW'(FIFO_DEPTH));
    do_pop   = bus.cdb_req && bus.cdb_grant
               && !bus.flush;
    do_push  = valid_in && !bus.flush
               && (!full || do_pop);
    drop     = valid_in && !bus.flush
               && full && !do_pop;
  end

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // entry storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push)
      mem[tail] <= '{tag: bus.Dest_in, data: result};
  end

  // CDB drive only in the granted pop cycle
  always_comb begin
    bus.cdb_req           = (count != '0);
    bus.CDB_ALU_ROB_index = '0;
    bus.CDB_ALU_data      = '0;
    if (do_pop) begin
      bus.CDB_ALU_ROB_index = mem[head].tag;
      bus.CDB_ALU_data      = mem[head].data;
    end
  end

  assign fifo_count  = count;
  assign almost_full = (count >= CW'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_alu_cdb_writer.sv
// Scoreboard bench for alu_cdb_writer.
// Stimulus pushes expected broadcasts; monitor pops them.
module tb_alu_cdb_writer;

  logic       clk;
  logic       rst;
  logic [2:0] fifo_count;
  logic       almost_full;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  alu_cdb_writer_if bus();

  alu_cdb_writer #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fifo_count  (fifo_count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0] d);
    bus.Op_in   = op;
    bus.Vj_in   = a;
    bus.Vk_in   = b;
    bus.Dest_in = d;
  endtask

  task automatic send(input logic [3:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [3:0] d,
                      input logic [31:0] e);
    drive(op, a, b, d);
    exp_q.push_back('{tag: d, data: e});
  endtask

  task automatic bubble();
    drive(4'd0, 32'd0, 32'd0, 4'd0);
  endtask

  // monitor: every nonzero broadcast must match queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.CDB_ALU_ROB_index != 4'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bcast",
            {28'd0, bus.CDB_ALU_ROB_index}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("bcast_tag",
            {28'd0, bus.CDB_ALU_ROB_index},
            {28'd0, e.tag});
        chk("bcast_data", bus.CDB_ALU_data, e.data);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.cdb_grant = 1'b0;
    bubble();
    #3;
    chk("rst_req", {31'd0, bus.cdb_req}, 32'd0);
    chk("rst_cnt", {29'd0, fifo_count}, 32'd0);
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_idx",
        {28'd0, bus.CDB_ALU_ROB_index}, 32'd0);
    step();
    rst = 1'b0;

    // ADD 5+7 -> tag 3 data 12 next cycle
    bus.cdb_grant = 1'b1;
    send(`ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12);
    step();
    bubble();
    step();
    chk("add_after_idx",
        {28'd0, bus.CDB_ALU_ROB_index}, 32'd0);
    chk("add_after_cnt", {29'd0, fifo_count}, 32'd0);

    // opcode sweep, grant held, one broadcast per cycle
    send(`ALU_SRA, 32'h8000_0000, 32'd4, 4'd4,
         32'hF800_0000);
    step();
    send(`ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 4'd5,
         32'd1);
    step();
    send(4'd15, 32'd9, 32'd9, 4'd6, 32'd0);
    step();
    send(`ALU_SUB, 32'd3, 32'd5, 4'd7,
         32'hFFFF_FFFE);
    step();
    send(`ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00,
         4'd8, 32'h00F0_1200);
    step();
    send(`ALU_OR, 32'hA000_0001, 32'h0500_0010,
         4'd9, 32'hA500_0011);
    step();
    send(`ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F,
         4'd10, 32'hF0F0_0F0F);
    step();
    send(`ALU_SLL, 32'd1, 32'h0000_0023, 4'd11,
         32'd8);
    step();
    send(`ALU_SRL, 32'h8000_0000, 32'd31, 4'd12,
         32'd1);
    step();
    send(`ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd13,
         32'd1);
    step();
    send(`ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd14,
         32'd0);
    step();
    send(`ALU_LUI, 32'd7, 32'h1234_5000, 4'd15,
         32'h1234_5000);
    step();
    bubble();
    repeat (3) step();
    chk("sweep_cnt", {29'd0, fifo_count}, 32'd0);

    // fill to full, then pop+push while full
    bus.cdb_grant = 1'b0;
    send(`ALU_ADD, 32'd1, 32'd100, 4'd1, 32'd101);
    step();
    send(`ALU_ADD, 32'd2, 32'd100, 4'd2, 32'd102);
    step();
    bubble();
    chk("cnt2_af", {31'd0, almost_full}, 32'd0);
    send(`ALU_ADD, 32'd3, 32'd100, 4'd3, 32'd103);
    step();
    bubble();
    chk("cnt3_af", {31'd0, almost_full}, 32'd1);
    send(`ALU_ADD, 32'd4, 32'd100, 4'd4, 32'd104);
    step();
    chk("full_cnt", {29'd0, fifo_count}, 32'd4);
    chk("full_af", {31'd0, almost_full}, 32'd1);
    chk("full_ovf", {31'd0, overflow}, 32'd0);
    bus.cdb_grant = 1'b1;
    send(`ALU_ADD, 32'd6, 32'd100, 4'd6, 32'd106);
    step();
    bubble();
    chk("pp_cnt", {29'd0, fifo_count}, 32'd4);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    repeat (5) step();
    chk("pp_drain", {29'd0, fifo_count}, 32'd0);

    // five inputs, grant low: fifth is dropped
    bus.cdb_grant = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      send(`ALU_SUB, 32'd100, 32'(d), 4'(d),
           32'd100 - 32'(d));
      step();
    end
    drive(`ALU_SUB, 32'd100, 32'd5, 4'd5);
    step();
    bubble();
    chk("ovf_cnt", {29'd0, fifo_count}, 32'd4);
    chk("ovf_af", {31'd0, almost_full}, 32'd1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    bus.cdb_grant = 1'b1;
    repeat (6) step();
    chk("ovf_drain", {29'd0, fifo_count}, 32'd0);

    // flush with 3 queued and a same-cycle input
    bus.cdb_grant = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      send(`ALU_ADD, 32'(d), 32'd0, 4'(d), 32'(d));
      step();
    end
    drive(`ALU_ADD, 32'd7, 32'd0, 4'd7);
    bus.cdb_grant = 1'b1;
    bus.flush     = 1'b1;
    exp_q.delete();
    #1;
    chk("flush_idx",
        {28'd0, bus.CDB_ALU_ROB_index}, 32'd0);
    step();
    bus.flush = 1'b0;
    bubble();
    chk("flush_cnt", {29'd0, fifo_count}, 32'd0);
    chk("flush_req", {31'd0, bus.cdb_req}, 32'd0);
    chk("flush_ovf", {31'd0, overflow}, 32'd1);
    repeat (3) step();

    // async reset with 2 queued while granted
    bus.cdb_grant = 1'b0;
    send(`ALU_ADD, 32'd1, 32'd1, 4'd1, 32'd2);
    step();
    send(`ALU_ADD, 32'd2, 32'd2, 4'd2, 32'd4);
    step();
    bubble();
    bus.cdb_grant = 1'b1;
    #1;
    chk("pre_rst_idx",
        {28'd0, bus.CDB_ALU_ROB_index}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_idx",
        {28'd0, bus.CDB_ALU_ROB_index}, 32'd0);
    chk("arst_data", bus.CDB_ALU_data, 32'd0);
    chk("arst_req", {31'd0, bus.cdb_req}, 32'd0);
    chk("arst_cnt", {29'd0, fifo_count}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    step();
    step();
    rst = 1'b0;

    // first edge after reset accepts input
    send(`ALU_ADD, 32'd2, 32'd3, 4'd9, 32'd5);
    step();
    bubble();
    repeat (3) step();
    chk("end_cnt", {29'd0, fifo_count}, 32'd0);
    chk("exp_left", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
